// File: rtl/amp_power_seq.sv
// rtl/amp_power_seq.sv - class-D amplifier power-up/down sequencer
// Sequences enable, settle, I2C init table, I2S lock wait and unmute; reverses on shutdown.
module amp_power_seq #(
    parameter int SETTLE_CYC = 4096,
    parameter int RAMP_CYC   = 2048,
    parameter int N_INIT     = 4,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = (N_INIT > 1) ? $clog2(N_INIT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             amp_en_req,
    input  logic             i2s_lock,
    input  logic [15:0]      init_data,
    output logic [IDX_W-1:0] init_idx,
    output logic             i2c_req,
    output logic [7:0]       i2c_addr,
    output logic [7:0]       i2c_data,
    input  logic             i2c_ack,
    input  logic             i2c_err,
    output logic             amp_nenable,
    output logic             amp_nmute,
    output logic             fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_INIT      = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4,
        ST_RAMP      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_INIT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic               i2c_req_q, i2c_req_d;
    logic [7:0]         i2c_addr_q, i2c_addr_d;
    logic [7:0]         i2c_data_q, i2c_data_d;
    logic               nenable_q, nenable_d;
    logic               nmute_q, nmute_d;
    logic               fault_q, fault_d;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        i2c_req_d  = i2c_req_q;
        i2c_addr_d = i2c_addr_q;
        i2c_data_d = i2c_data_q;

        case (state_q)
            ST_OFF: begin
                if (amp_en_req) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!amp_en_req) begin
                    state_d = ST_RAMP;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d    = ST_INIT;
                    i2c_req_d  = 1'b1;
                    i2c_addr_d = init_data[15:8];
                    i2c_data_d = init_data[7:0];
                end
            end
            ST_INIT: begin
                // An outstanding write always completes before shutdown is honoured.
                if (i2c_req_q) begin
                    if (i2c_err) begin
                        state_d   = ST_FAULT;
                        i2c_req_d = 1'b0;
                    end else if (i2c_ack) begin
                        i2c_req_d = 1'b0;
                        if (!amp_en_req) begin
                            state_d = ST_RAMP;
                        end else if (init_idx_q == IDX_LAST) begin
                            state_d = ST_WAIT_LOCK;
                        end else begin
                            init_idx_d = init_idx_q + IDX_W'(1);
                        end
                    end
                end else if (!amp_en_req) begin
                    state_d = ST_RAMP;
                end else begin
                    i2c_req_d  = 1'b1;
                    i2c_addr_d = init_data[15:8];
                    i2c_data_d = init_data[7:0];
                end
            end
            ST_WAIT_LOCK: begin
                if (!amp_en_req)   state_d = ST_RAMP;
                else if (i2s_lock) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!amp_en_req)    state_d = ST_RAMP;
                else if (!i2s_lock) state_d = ST_WAIT_LOCK;
            end
            ST_RAMP: begin
                if (cnt_q == RAMP_LAST) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (!amp_en_req) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        if (state_d != ST_INIT) init_idx_d = '0;
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

        // Pin levels derive from the next state so they change on the entry edge.
        nenable_d = (state_d == ST_OFF) || (state_d == ST_FAULT);
        nmute_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            init_idx_q <= '0;
            i2c_req_q  <= 1'b0;
            i2c_addr_q <= 8'h00;
            i2c_data_q <= 8'h00;
            nenable_q  <= 1'b1;
            nmute_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            i2c_req_q  <= i2c_req_d;
            i2c_addr_q <= i2c_addr_d;
            i2c_data_q <= i2c_data_d;
            nenable_q  <= nenable_d;
            nmute_q    <= nmute_d;
            fault_q    <= fault_d;
        end
    end

    assign init_idx    = init_idx_q;
    assign i2c_req     = i2c_req_q;
    assign i2c_addr    = i2c_addr_q;
    assign i2c_data    = i2c_data_q;
    assign amp_nenable = nenable_q;
    assign amp_nmute   = nmute_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule
